// File: rtl/rename_map_ckpt.sv
// rename_map_ckpt
// Register alias table with branch checkpoints for the dispatch stage.
// Each cycle it renames up to N_WAY instructions. An older way in the same
// bundle forwards its destination to younger sources, and a CDB tag that
// completes in the same cycle forwards its readiness. A circular set of map
// snapshots lets a mispredicted branch restore the speculative map in one cycle.
//
// Ports
//   clock, reset           clock; synchronous active-high reset
//   dis_valid/dest/src1/src2/new_preg   dispatch bundle; way 0 is the oldest
//   src1/src2_preg, src1/src2_ready     renamed source tags and their readiness
//   old_preg               previous mapping of each destination (freed at retire)
//   cdb_valid/cdb_preg     completion broadcasts
//   br_save/br_way         take a checkpoint after way br_way
//   br_ckpt_id/ckpt_full   slot this save will use / no free slot
//   recover_valid/id       restore the map from a slot and drop younger slots
//   release_valid          oldest branch retired; free the head slot
module rename_map_ckpt #(
   parameter  int N_WAY     = 2,
   parameter  int ARCH_REGS = 32,
   parameter  int PHYS_REGS = 64,
   parameter  int N_CKPT    = 4,
   localparam int PR_W = $clog2(PHYS_REGS),
   localparam int AR_W = $clog2(ARCH_REGS),
   localparam int CK_W = $clog2(N_CKPT),
   localparam int BW_W = (N_WAY > 1) ? $clog2(N_WAY) : 1
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [N_WAY-1:0]            dis_valid,
   input  logic [N_WAY-1:0][AR_W-1:0]  dis_dest,
   input  logic [N_WAY-1:0][AR_W-1:0]  dis_src1,
   input  logic [N_WAY-1:0][AR_W-1:0]  dis_src2,
   input  logic [N_WAY-1:0][PR_W-1:0]  dis_new_preg,
   output logic [N_WAY-1:0][PR_W-1:0]  src1_preg,
   output logic [N_WAY-1:0][PR_W-1:0]  src2_preg,
   output logic [N_WAY-1:0]            src1_ready,
   output logic [N_WAY-1:0]            src2_ready,
   output logic [N_WAY-1:0][PR_W-1:0]  old_preg,
   input  logic [N_WAY-1:0]            cdb_valid,
   input  logic [N_WAY-1:0][PR_W-1:0]  cdb_preg,
   input  logic                        br_save,
   input  logic [BW_W-1:0]             br_way,
   output logic [CK_W-1:0]             br_ckpt_id,
   output logic                        ckpt_full,
   input  logic                        recover_valid,
   input  logic [CK_W-1:0]             recover_id,
   input  logic                        release_valid
);

   logic [PR_W-1:0]      map_q [ARCH_REGS];
   logic [PR_W-1:0]      map_d [ARCH_REGS];
   logic [PR_W-1:0]      save_map [ARCH_REGS];
   logic [PR_W-1:0]      ckpt_q [N_CKPT][ARCH_REGS];
   logic [PHYS_REGS-1:0] ready_q, ready_d;
   logic [PHYS_REGS-1:0] cdb_set;
   logic [CK_W-1:0]      head_q, head_d, tail_q, tail_d;
   logic [CK_W:0]        count_q, count_d;
   logic                 do_save, do_rel;

   assign ckpt_full  = (count_q == (CK_W+1)'(N_CKPT));
   assign br_ckpt_id = tail_q;
   assign do_rel     = release_valid && (count_q != '0);
   assign do_save    = br_save && !ckpt_full && !recover_valid;

   // One-hot view of every tag completing this cycle; it serves both the
   // lookup bypass and the ready-table update.
   always_comb begin
      cdb_set = '0;
      for (int c = 0; c < N_WAY; c++)
         if (cdb_valid[c]) cdb_set[cdb_preg[c]] = 1'b1;
   end

   // Tag lookup for src1, src2 and dest of every way. Walking the older ways
   // in order leaves the youngest matching producer as the result.
   always_comb begin
      logic [AR_W-1:0] op;
      logic [PR_W-1:0] tag;
      logic            rdy;
      src1_preg  = '0;
      src2_preg  = '0;
      src1_ready = '0;
      src2_ready = '0;
      old_preg   = '0;
      for (int n = 0; n < N_WAY; n++) begin
         for (int j = 0; j < 3; j++) begin
            op  = (j == 0) ? dis_src1[n] : (j == 1) ? dis_src2[n] : dis_dest[n];
            tag = map_q[op];
            rdy = ready_q[tag] | cdb_set[tag];
            for (int k = 0; k < n; k++)
               if (dis_valid[k] && dis_dest[k] == op) begin
                  tag = dis_new_preg[k];
                  rdy = 1'b0;
               end
            if (op == '0) begin
               tag = '0;
               rdy = 1'b1;
            end
            case (j)
               0:       begin src1_preg[n] = tag; src1_ready[n] = rdy; end
               1:       begin src2_preg[n] = tag; src2_ready[n] = rdy; end
               default: old_preg[n] = tag;
            endcase
         end
      end
   end

   // Map / ready next state. save_map captures the map partway through the
   // bundle, right after the branch's way has been applied.
   always_comb begin
      for (int r = 0; r < ARCH_REGS; r++) begin
         map_d[r]    = map_q[r];
         save_map[r] = map_q[r];
      end
      for (int k = 0; k < N_WAY; k++) begin
         if (dis_valid[k] && dis_dest[k] != '0) map_d[dis_dest[k]] = dis_new_preg[k];
         if (BW_W'(k) == br_way)
            for (int r = 0; r < ARCH_REGS; r++) save_map[r] = map_d[r];
      end
      if (recover_valid)
         for (int r = 0; r < ARCH_REGS; r++) map_d[r] = ckpt_q[recover_id][r];

      ready_d = ready_q;
      if (!recover_valid)
         for (int k = 0; k < N_WAY; k++)
            if (dis_valid[k] && dis_dest[k] != '0) ready_d[dis_new_preg[k]] = 1'b0;
      // Completion is applied last so it beats a same-cycle dispatch clear.
      ready_d = ready_d | cdb_set;
   end

   // Checkpoint ring pointers.
   always_comb begin
      logic [CK_W-1:0] diff;
      head_d  = head_q + (do_rel ? CK_W'(1) : CK_W'(0));
      tail_d  = tail_q;
      count_d = count_q;
      diff    = '0;
      if (recover_valid) begin
         tail_d = recover_id + CK_W'(1);
         diff   = tail_d - head_d;
         // head==tail is ambiguous; it is empty only if the restored slot
         // itself was the one released this cycle.
         if (diff == '0 && !(do_rel && recover_id == head_q))
            count_d = (CK_W+1)'(N_CKPT);
         else
            count_d = {1'b0, diff};
      end else begin
         if (do_save) tail_d = tail_q + CK_W'(1);
         count_d = count_q + (do_save ? (CK_W+1)'(1) : '0) - (do_rel ? (CK_W+1)'(1) : '0);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= PR_W'(i);
         ready_q <= '1;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= map_d[i];
         ready_q <= ready_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Snapshot storage needs no reset: a slot is only read after being written.
   always_ff @(posedge clock) begin
      if (!reset && do_save)
         for (int r = 0; r < ARCH_REGS; r++) ckpt_q[tail_q][r] <= save_map[r];
   end

endmodule

// File: tb/tb_rename_map_ckpt.sv
module tb_rename_map_ckpt;
   localparam int N_WAY = 2, ARCH_REGS = 32, PHYS_REGS = 64, N_CKPT = 4;
   localparam int PR_W = 6, AR_W = 5, CK_W = 2;

   logic clock = 0, reset = 1;
   logic [N_WAY-1:0]            dis_valid;
   logic [N_WAY-1:0][AR_W-1:0]  dis_dest, dis_src1, dis_src2;
   logic [N_WAY-1:0][PR_W-1:0]  dis_new_preg;
   logic [N_WAY-1:0][PR_W-1:0]  src1_preg, src2_preg, old_preg;
   logic [N_WAY-1:0]            src1_ready, src2_ready;
   logic [N_WAY-1:0]            cdb_valid;
   logic [N_WAY-1:0][PR_W-1:0]  cdb_preg;
   logic                        br_save;
   logic [0:0]                  br_way;
   logic [CK_W-1:0]             br_ckpt_id;
   logic                        ckpt_full;
   logic                        recover_valid;
   logic [CK_W-1:0]             recover_id;
   logic                        release_valid;

   rename_map_ckpt #(.N_WAY(N_WAY), .ARCH_REGS(ARCH_REGS), .PHYS_REGS(PHYS_REGS), .N_CKPT(N_CKPT)) dut (
      .clock(clock), .reset(reset),
      .dis_valid(dis_valid), .dis_dest(dis_dest), .dis_src1(dis_src1), .dis_src2(dis_src2),
      .dis_new_preg(dis_new_preg),
      .src1_preg(src1_preg), .src2_preg(src2_preg), .src1_ready(src1_ready), .src2_ready(src2_ready),
      .old_preg(old_preg), .cdb_valid(cdb_valid), .cdb_preg(cdb_preg),
      .br_save(br_save), .br_way(br_way), .br_ckpt_id(br_ckpt_id), .ckpt_full(ckpt_full),
      .recover_valid(recover_valid), .recover_id(recover_id), .release_valid(release_valid));

   always #5 clock = ~clock;

   int pass_cnt = 0, chk_cnt = 0;

   task automatic chk(input string nm, input int act, input int req);
      chk_cnt++;
      if (act == req) pass_cnt++;
      else $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
   endtask

   // ---------------- behavioural model ----------------
   int m_map [ARCH_REGS];
   bit m_ready [PHYS_REGS];
   int m_ck [N_CKPT][ARCH_REGS];
   int live [$];              // live checkpoint slot ids, oldest first
   int m_next;                // slot the next save will take
   int snap [ARCH_REGS];
   int nmap [ARCH_REGS];

   // Mapping of reg r as seen after applying ways 0..lim of the current bundle.
   function automatic int map_after(input int r, input int lim);
      if (r == 0) return 0;
      for (int k = lim; k >= 0; k--)
         if (dis_valid[k] && int'(dis_dest[k]) == r) return int'(dis_new_preg[k]);
      return m_map[r];
   endfunction

   function automatic bit on_cdb(input int p);
      for (int c = 0; c < N_WAY; c++)
         if (cdb_valid[c] && int'(cdb_preg[c]) == p) return 1'b1;
      return 1'b0;
   endfunction

   task automatic exp_lookup(input int a, input int n, output int p, output int rd);
      p = map_after(a, n - 1);
      if (a == 0) rd = 1;
      else if (p != m_map[a]) rd = 0;
      else rd = (m_ready[p] || on_cdb(p)) ? 1 : 0;
      // an older way can legally rename to the same preg only in odd stimuli; keep rule explicit
      for (int k = 0; k < n; k++)
         if (a != 0 && dis_valid[k] && int'(dis_dest[k]) == a) rd = 0;
   endtask

   always @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < ARCH_REGS; i++) m_map[i] = i;
         for (int i = 0; i < PHYS_REGS; i++) m_ready[i] = 1'b1;
         live.delete();
         m_next = 0;
      end else begin
         automatic bit was_full = (live.size() == N_CKPT);
         automatic bit rel_ok = release_valid && (live.size() > 0);
         if (recover_valid) begin
            automatic int rid = int'(recover_id);
            automatic int idx = -1;
            if (rel_ok) void'(live.pop_front());
            for (int i = 0; i < live.size(); i++) if (live[i] == rid) idx = i;
            if (idx < 0) live.delete();
            else while (live.size() > idx + 1) void'(live.pop_back());
            m_next = (rid + 1) % N_CKPT;
            m_map = m_ck[rid];
         end else begin
            for (int r = 0; r < ARCH_REGS; r++) begin
               snap[r] = map_after(r, int'(br_way));
               nmap[r] = map_after(r, N_WAY - 1);
            end
            for (int k = 0; k < N_WAY; k++)
               if (dis_valid[k] && dis_dest[k] != 0) m_ready[dis_new_preg[k]] = 1'b0;
            if (br_save && !was_full) begin
               m_ck[m_next] = snap;
               live.push_back(m_next);
               m_next = (m_next + 1) % N_CKPT;
            end
            if (rel_ok) void'(live.pop_front());
            m_map = nmap;
         end
         for (int c = 0; c < N_WAY; c++) if (cdb_valid[c]) m_ready[cdb_preg[c]] = 1'b1;
      end
   end

   // Every cycle out of reset, the outputs must match the model.
   always @(negedge clock) begin
      if (!reset) begin
         int p, rd;
         for (int n = 0; n < N_WAY; n++) begin
            exp_lookup(int'(dis_src1[n]), n, p, rd);
            chk("src1_preg", int'(src1_preg[n]), p);
            chk("src1_ready", int'(src1_ready[n]), rd);
            exp_lookup(int'(dis_src2[n]), n, p, rd);
            chk("src2_preg", int'(src2_preg[n]), p);
            chk("src2_ready", int'(src2_ready[n]), rd);
            exp_lookup(int'(dis_dest[n]), n, p, rd);
            chk("old_preg", int'(old_preg[n]), p);
         end
         chk("ckpt_full", int'(ckpt_full), (live.size() == N_CKPT) ? 1 : 0);
         chk("br_ckpt_id", int'(br_ckpt_id), m_next);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic clr();
      dis_valid = '0; dis_dest = '0; dis_src1 = '0; dis_src2 = '0; dis_new_preg = '0;
      cdb_valid = '0; cdb_preg = '0; br_save = 0; br_way = '0;
      recover_valid = 0; recover_id = '0; release_valid = 0;
   endtask

   task automatic set_way(input int w, input bit v, input int d, input int s1, input int s2, input int np);
      dis_valid[w] = v; dis_dest[w] = AR_W'(d); dis_src1[w] = AR_W'(s1);
      dis_src2[w] = AR_W'(s2); dis_new_preg[w] = PR_W'(np);
   endtask

   task automatic cdb(input int c, input int p);
      cdb_valid[c] = 1'b1; cdb_preg[c] = PR_W'(p);
   endtask

   task automatic next_cyc();
      @(posedge clock); #1; clr();
   endtask

   initial begin
      clr();
      reset = 1;
      repeat (2) @(posedge clock);
      #1 reset = 0;

      // reset state lookups
      set_way(0, 0, 0, 5, 0, 0);
      @(negedge clock);
      chk("rst_src1_preg", int'(src1_preg[0]), 5);
      chk("rst_src1_ready", int'(src1_ready[0]), 1);
      chk("rst_src2_preg", int'(src2_preg[0]), 0);
      chk("rst_src2_ready", int'(src2_ready[0]), 1);
      chk("rst_ckpt_full", int'(ckpt_full), 0);
      chk("rst_ckpt_id", int'(br_ckpt_id), 0);
      next_cyc();

      // intra-bundle forwarding
      set_way(0, 1, 3, 1, 2, 40);
      set_way(1, 1, 3, 3, 0, 41);
      @(negedge clock);
      chk("fwd_src1_preg", int'(src1_preg[1]), 40);
      chk("fwd_src1_ready", int'(src1_ready[1]), 0);
      chk("fwd_old_preg1", int'(old_preg[1]), 40);
      chk("fwd_old_preg0", int'(old_preg[0]), 3);
      next_cyc();

      set_way(0, 0, 0, 3, 0, 0);
      @(negedge clock);
      chk("map3_preg", int'(src1_preg[0]), 41);
      chk("map3_ready", int'(src1_ready[0]), 0);
      next_cyc();

      // CDB bypass in the same cycle, then persisted
      set_way(0, 0, 0, 3, 0, 0); cdb(0, 41);
      @(negedge clock);
      chk("cdb_bypass", int'(src1_ready[0]), 1);
      next_cyc();
      set_way(0, 0, 0, 3, 0, 0);
      @(negedge clock);
      chk("cdb_persist", int'(src1_ready[0]), 1);
      next_cyc();

      // dispatch clear and CDB set on the same preg: CDB wins
      set_way(0, 1, 4, 0, 0, 42); set_way(1, 0, 0, 4, 0, 0); cdb(1, 42);
      @(negedge clock);
      chk("ovr_preg", int'(src1_preg[1]), 42);
      chk("ovr_ready", int'(src1_ready[1]), 0);
      next_cyc();
      set_way(0, 0, 0, 4, 0, 0); set_way(1, 1, 0, 0, 0, 63);
      @(negedge clock);
      chk("cdb_wins", int'(src1_ready[0]), 1);
      next_cyc();

      // checkpoint, overwrite, recover
      set_way(0, 1, 7, 0, 0, 50); set_way(1, 1, 0, 0, 0, 0); br_save = 1; br_way = 1'b1;
      @(negedge clock);
      chk("save0_id", int'(br_ckpt_id), 0);
      next_cyc();
      set_way(0, 1, 7, 0, 0, 51);
      @(negedge clock);
      chk("old_r7", int'(old_preg[0]), 50);
      next_cyc();
      set_way(0, 0, 0, 7, 0, 0); recover_valid = 1; recover_id = 2'd0;
      @(negedge clock);
      chk("pre_recover_r7", int'(src1_preg[0]), 51);
      next_cyc();
      set_way(0, 1, 13, 7, 0, 60);
      @(negedge clock);
      chk("recovered_r7", int'(src1_preg[0]), 50);
      chk("recover_tail", int'(br_ckpt_id), 1);
      next_cyc();

      // fill the ring; br_way=0 excludes way1 from the snapshot
      set_way(0, 1, 10, 0, 0, 55); set_way(1, 1, 11, 0, 0, 56); br_save = 1; br_way = 1'b0;
      next_cyc();
      br_save = 1; cdb(0, 60);
      next_cyc();
      br_save = 1;
      @(negedge clock);
      chk("pre_full", int'(ckpt_full), 0);
      next_cyc();
      br_save = 1; set_way(0, 1, 12, 0, 0, 57);
      @(negedge clock);
      chk("full", int'(ckpt_full), 1);
      chk("full_id", int'(br_ckpt_id), 0);
      next_cyc();
      release_valid = 1;
      @(negedge clock);
      chk("save_ignored", int'(br_ckpt_id), 0);
      next_cyc();
      br_save = 1;
      @(negedge clock);
      chk("after_release_full", int'(ckpt_full), 0);
      chk("wrap_id", int'(br_ckpt_id), 0);
      next_cyc();

      // recover with a concurrent dispatch: dispatch dropped
      recover_valid = 1; recover_id = 2'd1; set_way(0, 1, 9, 9, 0, 60);
      next_cyc();
      set_way(0, 0, 0, 9, 13, 0); set_way(1, 0, 0, 11, 10, 0);
      @(negedge clock);
      chk("rec_r9", int'(src1_preg[0]), 9);
      chk("rec_r13", int'(src2_preg[0]), 60);
      chk("rec_ready60", int'(src2_ready[0]), 1);
      chk("rec_r11_excl", int'(src1_preg[1]), 11);
      chk("rec_r10", int'(src2_preg[1]), 55);
      chk("rec_ready55", int'(src2_ready[1]), 0);
      chk("rec_tail", int'(br_ckpt_id), 2);
      next_cyc();

      // release to empty, extra release ignored, recover+release together
      release_valid = 1; next_cyc();
      release_valid = 1; next_cyc();
      br_save = 1;
      @(negedge clock);
      chk("empty_id", int'(br_ckpt_id), 2);
      next_cyc();
      br_save = 1; next_cyc();
      recover_valid = 1; recover_id = 2'd3; release_valid = 1; next_cyc();
      for (int i = 0; i < 3; i++) begin br_save = 1; next_cyc(); end
      @(negedge clock);
      chk("refill_full", int'(ckpt_full), 1);
      chk("refill_id", int'(br_ckpt_id), 3);

      // reset mid-operation
      @(posedge clock); #1 reset = 1;
      @(posedge clock); #1 reset = 0;
      set_way(0, 0, 0, 7, 0, 0);
      @(negedge clock);
      chk("reset_r7", int'(src1_preg[0]), 7);
      chk("reset_full", int'(ckpt_full), 0);
      chk("reset_id", int'(br_ckpt_id), 0);
      next_cyc();

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
